data_bus_master: RTL

- Memory-stage bus master sitting between the pipeline MEM stage and the avalon_bus data-bus decoder.
- Accepts one load or store per instruction from the pipeline and drives the bus address, write data and read/write strobes.
- Holds each request until Waitreq drops, waits out the device read latency, and returns load data.
- Stalls the pipeline for the whole transaction and flags bus errors: timeout and illegal requests.

---
 rtl/data_bus_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_bus_master.sv
// data_bus_master: memory-stage bus master between the pipeline MEM stage and the
// data-bus decoder. Takes one load or store per instruction and drives the bus
// address, write data and read/write strobes. It holds the request until waitreq
// drops, waits out the device read latency, and returns load data. The pipeline is
// stalled for the whole transaction, and a one-cycle done pulse ends it. A bus
// error is flagged when waitreq stays high too long or the request is illegal.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   mem_read_i, mem_write_i  pipeline load / store request
//   mem_addr_i, store_data_i request address ([15:12] = device select) and store data
//   stall_o                  hold the MEM stage (combinational)
//   done_o                   one-cycle completion pulse
//   load_data_o              load result, valid with done_o
//   bus_error_o              timeout or illegal request, valid with done_o
//   data_addr_o              registered bus address
//   bus_wr_data_o            registered bus write data
//   read_data_o              bus read strobe
//   write_data_o             bus write strobe
//   bus_rd_data_i            bus read data
//   waitreq_i                bus wait request
module data_bus_master #(
    parameter int unsigned READ_LATENCY = 1,  // 1..7
    parameter int unsigned TIMEOUT      = 15  // 1..255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] store_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [15:0] load_data_o,
    output logic        bus_error_o,
    output logic [15:0] data_addr_o,
    output logic [15:0] bus_wr_data_o,
    output logic        read_data_o,
    output logic        write_data_o,
    input  logic [15:0] bus_rd_data_i,
    input  logic        waitreq_i
);

    typedef enum logic [1:0] {StIdle, StReq, StRdWait, StResp} state_e;

    localparam logic [2:0] LatInit = 3'(READ_LATENCY - 1);
    // Abort on the edge where the count would reach TIMEOUT.
    localparam logic [7:0] ToLast  = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        is_read_q;
    logic [7:0]  to_cnt_q;
    logic [2:0]  lat_cnt_q;
    logic [15:0] data_addr_q;
    logic [15:0] bus_wr_data_q;
    logic [15:0] load_data_q;
    logic        read_q;
    logic        write_q;
    logic        done_q;
    logic        bus_error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            is_read_q     <= 1'b0;
            to_cnt_q      <= '0;
            lat_cnt_q     <= '0;
            data_addr_q   <= '0;
            bus_wr_data_q <= '0;
            load_data_q   <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            done_q        <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_read_i && mem_write_i) begin
                        // Illegal: no bus activity, report the error straight away.
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b1;
                        load_data_q <= '0;
                        state_q     <= StResp;
                    end else if (mem_read_i || mem_write_i) begin
                        data_addr_q   <= mem_addr_i;
                        bus_wr_data_q <= store_data_i;
                        is_read_q     <= mem_read_i;
                        read_q        <= mem_read_i;
                        write_q       <= mem_write_i;
                        to_cnt_q      <= '0;
                        state_q       <= StReq;
                    end
                end
                StReq: begin
                    if (!waitreq_i) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (is_read_q) begin
                            lat_cnt_q <= LatInit;
                            state_q   <= StRdWait;
                        end else begin
                            done_q      <= 1'b1;
                            bus_error_q <= 1'b0;
                            load_data_q <= '0;
                            state_q     <= StResp;
                        end
                    end else if (to_cnt_q == ToLast) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b1;
                        load_data_q <= '0;
                        state_q     <= StResp;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end
                StRdWait: begin
                    if (lat_cnt_q == 3'd0) begin
                        load_data_q <= bus_rd_data_i;
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b0;
                        state_q     <= StResp;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    done_q      <= 1'b0;
                    bus_error_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stall_o       = (mem_read_i | mem_write_i) & ~done_q;
    assign done_o        = done_q;
    assign load_data_o   = load_data_q;
    assign bus_error_o   = bus_error_q;
    assign data_addr_o   = data_addr_q;
    assign bus_wr_data_o = bus_wr_data_q;
    assign read_data_o   = read_q;
    assign write_data_o  = write_q;

endmodule
